// File: rtl/clk_disp_12h_scan.sv
// Drives a 4-digit multiplexed common-anode 7-segment display as HH:MM (12-hour),
// with per-frame snapshot of the time inputs, a blinking colon and AM/PM tracking.
module clk_disp_12h_scan #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       rst_counters,
  input  logic [7:0] hr_12,
  input  logic [7:0] min_cnt,
  input  logic       sec_tick,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       pm
);

  localparam int unsigned   CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [6:0]    SEG_BLANK = 7'h7F;
  localparam logic [6:0]    SEG_DASH  = 7'h3F;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    digit_q, digit_d;
  logic [7:0]    snap_hr_q, snap_hr_d;
  logic [7:0]    snap_min_q, snap_min_d;
  logic [7:0]    hr_prev_q, hr_prev_d;
  logic          colon_q, colon_d;
  logic          pm_q, pm_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          dp_q, dp_d;
  logic [7:0]    src_hr, src_min;

  function automatic logic [6:0] font(input logic [7:0] d);
    logic [6:0] f;
    case (d)
      8'd0:    f = 7'h40;
      8'd1:    f = 7'h79;
      8'd2:    f = 7'h24;
      8'd3:    f = 7'h30;
      8'd4:    f = 7'h19;
      8'd5:    f = 7'h12;
      8'd6:    f = 7'h02;
      8'd7:    f = 7'h78;
      8'd8:    f = 7'h00;
      8'd9:    f = 7'h10;
      default: f = SEG_BLANK;
    endcase
    return f;
  endfunction

  // Segment pattern for one digit position; out-of-range inputs show a dash.
  function automatic logic [6:0] digit_seg(input logic [7:0] hr, input logic [7:0] mn,
                                           input logic [1:0] sel);
    logic [7:0] hd;
    logic [6:0] s;
    hd = (hr == 8'd0) ? 8'd12 : hr;
    case (sel)
      2'd0: s = (mn > 8'd59) ? SEG_DASH : font(mn % 8'd10);
      2'd1: s = (mn > 8'd59) ? SEG_DASH : font(mn / 8'd10);
      2'd2: s = (hr > 8'd11) ? SEG_DASH : font(hd % 8'd10);
      2'd3: begin
        if (hr > 8'd11) begin
          s = SEG_DASH;
        end else if (hd < 8'd10) begin
          s = SEG_BLANK;
        end else begin
          s = font(hd / 8'd10);
        end
      end
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  always_comb begin
    cnt_d      = cnt_q + CW'(1);
    digit_d    = digit_q;
    snap_hr_d  = snap_hr_q;
    snap_min_d = snap_min_q;
    seg_d      = seg_q;
    an_d       = an_q;
    dp_d       = dp_q;
    src_hr     = snap_hr_q;
    src_min    = snap_min_q;
    colon_d    = colon_q ^ sec_tick;
    pm_d       = pm_q ^ ((hr_prev_q == 8'd11) && (hr_12 == 8'd0));
    hr_prev_d  = hr_12;

    if (rst_counters) begin
      cnt_d      = '0;
      digit_d    = 2'd3;
      snap_hr_d  = 8'd0;
      snap_min_d = 8'd0;
      seg_d      = SEG_BLANK;
      an_d       = 4'hF;
      dp_d       = 1'b1;
      colon_d    = 1'b0;
      pm_d       = 1'b0;
      hr_prev_d  = 8'd0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      digit_d = digit_q + 2'd1;
      // Entering digit 0 starts a new frame: capture and show live values this edge.
      if (digit_q == 2'd3) begin
        snap_hr_d  = hr_12;
        snap_min_d = min_cnt;
        src_hr     = hr_12;
        src_min    = min_cnt;
      end else begin
        src_hr     = snap_hr_q;
        src_min    = snap_min_q;
      end
      seg_d = digit_seg(src_hr, src_min, digit_d);
      an_d  = ~(4'b0001 << digit_d);
      dp_d  = (digit_d == 2'd2) ? ~colon_q : 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      digit_q    <= 2'd3;
      snap_hr_q  <= 8'd0;
      snap_min_q <= 8'd0;
      hr_prev_q  <= 8'd0;
      colon_q    <= 1'b0;
      pm_q       <= 1'b0;
      seg_q      <= SEG_BLANK;
      an_q       <= 4'hF;
      dp_q       <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      digit_q    <= digit_d;
      snap_hr_q  <= snap_hr_d;
      snap_min_q <= snap_min_d;
      hr_prev_q  <= hr_prev_d;
      colon_q    <= colon_d;
      pm_q       <= pm_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      dp_q       <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;
  assign pm  = pm_q;

endmodule

// File: tb/tb_clk_disp_12h_scan.sv
// Scoreboard bench for clk_disp_12h_scan: a behavioural model predicts each display
// slot and the pm level; a monitor compares whenever the digit enables change.
module tb_clk_disp_12h_scan;

  localparam int P = 4;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } disp_t;

  typedef struct {
    int cyc;
    int hr;
    int mn;
    bit tick;
    bit rc;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rst_counters = 1'b0;
  logic [7:0] hr_12 = 8'd0;
  logic [7:0] min_cnt = 8'd0;
  logic       sec_tick = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       pm;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_go   = 1'b0;
  bit done     = 1'b0;

  disp_t disp_q[$];
  bit    pm_q[$];

  // Reference model state
  int         n_edge = 0;
  int         snap_h = 0;
  int         snap_m = 0;
  int         prev_h = 0;
  bit         colon_m = 1'b0;
  bit         pm_m = 1'b0;
  logic [3:0] cur_an = 4'hF;
  int         font_tbl[10] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78, 'h00, 'h10};

  clk_disp_12h_scan #(.REFRESH_DIV(P)) dut (
    .CLK(clk), .rst_n(rst_n), .rst_counters(rst_counters), .hr_12(hr_12),
    .min_cnt(min_cnt), .sec_tick(sec_tick), .seg(seg), .an(an), .dp(dp), .pm(pm)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int model_seg(input int h, input int m, input int dg);
    int hd;
    hd = (h == 0) ? 12 : h;
    if (dg >= 2) begin
      if (h > 11) return 'h3F;
      if (dg == 2) return font_tbl[hd % 10];
      return (hd < 10) ? 'h7F : font_tbl[hd / 10];
    end
    if (m > 59) return 'h3F;
    return (dg == 0) ? font_tbl[m % 10] : font_tbl[m / 10];
  endfunction

  task automatic set_disp(input logic [3:0] a, input int s, input bit d);
    disp_t e;
    if (a != cur_an) begin
      e.an  = a;
      e.seg = 7'(s);
      e.dp  = d;
      disp_q.push_back(e);
    end
    cur_an = a;
  endtask

  // Drive one cycle of inputs, predict the following rising edge, then advance.
  task automatic step(input bit rn, input bit rc, input int h, input int m, input bit t);
    int         dg;
    logic [3:0] a;
    rst_n        = rn;
    rst_counters = rc;
    hr_12        = 8'(h);
    min_cnt      = 8'(m);
    sec_tick     = t;
    if (!rn || rc) begin
      n_edge  = 0;
      colon_m = 1'b0;
      pm_m    = 1'b0;
      prev_h  = 0;
      set_disp(4'hF, 'h7F, 1'b1);
    end else begin
      n_edge++;
      if (n_edge % P == 0) begin
        dg = (n_edge / P - 1) % 4;
        if (dg == 0) begin
          snap_h = h;
          snap_m = m;
        end
        a = 4'b0001 << dg;
        set_disp(~a, model_seg(snap_h, snap_m, dg), (dg == 2) ? !colon_m : 1'b1);
      end
      if (prev_h == 11 && h == 0) pm_m = !pm_m;
      prev_h = h;
      if (t) colon_m = !colon_m;
    end
    pm_q.push_back(pm_m);
    @(negedge clk);
  endtask

  // Monitor: pm every cycle, full display word whenever the digit enables move.
  initial begin
    logic [3:0] last_an;
    disp_t      e;
    last_an = 4'hF;
    wait (mon_go);
    while (!done) begin
      @(posedge clk);
      #1;
      if (done) break;
      if (pm_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pm_underflow: got pm=%0b with no expectation queued", pm);
      end else begin
        check("pm", int'(pm), int'(pm_q.pop_front()));
      end
      if (an !== last_an) begin
        if (disp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL disp_unexpected: got an=%0h seg=%0h dp=%0b expected no change", an, seg, dp);
        end else begin
          e = disp_q.pop_front();
          check("an", int'(an), int'(e.an));
          check("seg", int'(seg), int'(e.seg));
          check("dp", int'(dp), int'(e.dp));
        end
        last_an = an;
      end
    end
  end

  initial begin
    stim_t tbl[16];
    int    h;
    int    m;
    int    r;
    tbl = '{'{20, 0, 5, 1'b0, 1'b0}, '{16, 3, 5, 1'b0, 1'b0}, '{4, 11, 5, 1'b0, 1'b0},
            '{4, 0, 5, 1'b0, 1'b0},  '{4, 11, 5, 1'b0, 1'b0}, '{4, 0, 5, 1'b0, 1'b0},
            '{4, 11, 5, 1'b0, 1'b0}, '{1, 11, 5, 1'b0, 1'b1}, '{20, 0, 7, 1'b0, 1'b0},
            '{8, 0, 7, 1'b0, 1'b0},  '{24, 0, 8, 1'b0, 1'b0}, '{20, 1, 30, 1'b1, 1'b0},
            '{20, 1, 30, 1'b1, 1'b0}, '{20, 15, 60, 1'b0, 1'b0}, '{20, 11, 60, 1'b0, 1'b0},
            '{20, 0, 60, 1'b0, 1'b0}};

    repeat (3) @(posedge clk);
    #1;
    check("rst_seg", int'(seg), 'h7F);
    check("rst_an", int'(an), 'hF);
    check("rst_dp", int'(dp), 1);
    check("rst_pm", int'(pm), 0);
    @(negedge clk);
    mon_go = 1'b1;

    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].cyc; c++) begin
        step(1'b1, tbl[i].rc && (c == 0), tbl[i].hr, tbl[i].mn, tbl[i].tick && (c == 0));
      end
    end

    h = 0;
    m = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        r = int'($urandom_range(0, 9));
        if (r < 3)      h = 11;
        else if (r < 6) h = 0;
        else if (r < 9) h = int'($urandom_range(0, 11));
        else            h = int'($urandom_range(12, 15));
      end
      if ($urandom_range(0, 9) == 0) m = int'($urandom_range(0, 63));
      step($urandom_range(0, 799) != 0, $urandom_range(0, 399) == 0, h, m,
           $urandom_range(0, 9) == 0);
    end

    done = 1'b1;
    check("disp_left", disp_q.size(), 0);
    check("pm_left", pm_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
